// File: rtl/result_text_writer.sv
// result_text_writer: captures four result words on a halt edge and writes a
// 4x16 character pass/fail report into the display buffer over a we/wr_ready handshake.
`default_nettype none

module result_text_writer #(
    parameter logic [31:0] EXP0 = 32'd55,
    parameter logic [31:0] EXP1 = 32'd987,
    parameter logic [31:0] EXP2 = 32'd97,
    parameter logic [31:0] EXP3 = 32'h00000315
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] val0,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [31:0] val3,
    input  logic        wr_ready,
    output logic        we,
    output logic [5:0]  waddr,
    output logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        pass_all
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [3:0][31:0]  val_q;
    logic [5:0]        idx_q;
    logic [5:0]        idx_d;
    logic              start_q;
    logic              held_q;
    logic              we_q;
    logic [5:0]        waddr_q;
    logic [7:0]        wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic [3:0]        ok_lat;
    logic [3:0]        ok_in;
    logic              start_edge;

    assign ok_lat = {val_q[3] == EXP3, val_q[2] == EXP2, val_q[1] == EXP1, val_q[0] == EXP0};
    assign ok_in  = {val3 == EXP3, val2 == EXP2, val1 == EXP1, val0 == EXP0};
    assign idx_d  = idx_q + 6'd1;

    // A start level that was already high when reset released must drop
    // before it can trigger a run; held_q blocks that stale edge.
    assign start_edge = start & ~start_q & ~held_q;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
    endfunction

    function automatic logic [7:0] char_of(input logic [5:0] a,
                                           input logic [3:0][31:0] v,
                                           input logic [3:0] ok);
        logic [1:0]  l;
        logic [3:0]  c;
        logic [31:0] sh;
        l  = a[5:4];
        c  = a[3:0];
        sh = v[l] >> {(4'd9 - c), 2'b00};
        case (c)
            4'd0:    return 8'h30 + {6'b0, l};
            4'd1:    return 8'h3D;
            4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9:
                     return hex_char(sh[3:0]);
            4'd11:   return ok[l] ? 8'h2B : 8'h2D;
            default: return 8'h20;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            held_q  <= 1'b1;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            start_q <= start;
            if (!start) held_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        val_q   <= {val3, val2, val1, val0};
                        pass_q  <= &ok_in;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    we_q    <= 1'b1;
                    waddr_q <= '0;
                    wdata_q <= char_of(6'd0, val_q, ok_lat);
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (we_q && wr_ready) begin
                        if (idx_q == 6'd63) begin
                            we_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_d;
                            waddr_q <= idx_d;
                            wdata_q <= char_of(idx_d, val_q, ok_lat);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_all = pass_q;

endmodule

`default_nettype wire
